// File: rtl/led_count_game_if.sv
// Player-facing signal bundle of the LED count game: mode/button inputs and display outputs.
// The game core takes the slave view; the board top or a bench drives the master view.
interface led_count_game_if #(
  parameter int N_LED = 16
);
  logic             i_active;
  logic             i_btn_go_stop;
  logic [N_LED-1:0] o_led;
  logic [19:0]      o_seg_data;
  logic [3:0]       o_dp_data;
  logic [7:0]       o_score;
  logic             o_win_pulse;

  modport master (
    output i_active, i_btn_go_stop,
    input  o_led, o_seg_data, o_dp_data, o_score, o_win_pulse
  );

  modport slave (
    input  i_active, i_btn_go_stop,
    output o_led, o_seg_data, o_dp_data, o_score, o_win_pulse
  );
endinterface

// File: rtl/led_count_game.sv
// LED count game: a bouncing bar runs until the player presses; a win needs the lit
// count to equal a pseudo-random target, with a limited number of tries per round.
module led_count_game #(
  parameter int N_LED       = 16,
  parameter int TICK_CYCLES = 100_000_000,
  parameter int MAX_TRIES   = 3
) (
  input logic             clk,
  input logic             reset,
  led_count_game_if.slave bus
);
  localparam int              TW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]      POS_TOP    = 4'(N_LED - 1);
  localparam logic [3:0]      POS_TOP_M1 = 4'(N_LED - 2);
  localparam logic [2:0]      TRIES_INIT = 3'(MAX_TRIES);
  localparam logic [4:0]      C_HYP = 5'd10, C_E = 5'd14, C_U = 5'd15, C_P = 5'd16;
  localparam logic [4:0]      C_O = 5'd17, C_D = 5'd19, C_N = 5'd20, C_L = 5'd21;
  localparam logic [4:0]      C_G = 5'd9, C_S = 5'd5;
  localparam logic [19:0]     SEG_DASHES = {C_HYP, C_HYP, C_HYP, C_HYP};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STOP, S_WIN, S_LOSE} state_t;

  state_t           r_state;
  logic [15:0]      r_sc;
  logic [15:0]      r_lfsr;
  logic             r_btn_prev;
  logic [TW-1:0]    r_tick_cnt;
  logic [3:0]       r_pos;
  logic             r_dir;          // 1 = moving up
  logic [N_LED-1:0] r_led;
  logic [19:0]      r_seg;
  logic [2:0]       r_tries;
  logic [7:0]       r_score;
  logic             r_win_pulse;
  logic [4:0]       r_cnt;
  logic [4:0]       r_target;
  logic             r_decide;

  logic             w_press;
  logic             w_tick;
  logic             w_fb;
  logic [15:0]      w_seed;
  logic [15:0]      w_lfsr_load;
  logic [4:0]       w_rnd;
  logic [4:0]       w_target_new;
  logic [N_LED-1:0] w_mask;

  function automatic logic [9:0] two_digit(input logic [4:0] v);
    return (v >= 5'd10) ? {5'd1, v - 5'd10} : {5'd0, v};
  endfunction

  function automatic logic [4:0] popcount(input logic [N_LED-1:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < N_LED; i++) s = s + {4'd0, v[i]};
    return s;
  endfunction

  assign w_press     = bus.i_btn_go_stop & ~r_btn_prev;
  assign w_tick      = (r_state == S_RUN) && (r_tick_cnt == TICK_LAST);
  assign w_fb        = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
  assign w_seed      = {r_sc[7:0], r_sc[15:8]} ^ 16'hACE1;
  assign w_lfsr_load = (w_seed == 16'd0) ? 16'd1 : w_seed;

  always_comb begin
    w_rnd = {1'b0, r_lfsr[3:0]};
    if (w_rnd >= 5'(N_LED)) w_rnd = w_rnd - 5'(N_LED);
    w_target_new = w_rnd + 5'd1;
  end

  // Bar fills from the current position up to the top LED.
  generate
    for (genvar gi = 0; gi < N_LED; gi++) begin : g_mask
      assign w_mask[gi] = (4'(gi) >= r_pos);
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_dp
      assign bus.o_dp_data[gi] = (r_tries > 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc       <= '0;
      r_lfsr     <= 16'hACE1;
      r_btn_prev <= 1'b0;
    end else begin
      r_sc       <= r_sc + 16'd1;
      r_btn_prev <= bus.i_btn_go_stop;
      r_lfsr     <= bus.i_active ? {r_lfsr[14:0], w_fb} : w_lfsr_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_led       <= '0;
      r_seg       <= SEG_DASHES;
      r_tries     <= TRIES_INIT;
      r_score     <= '0;
      r_win_pulse <= 1'b0;
      r_cnt       <= '0;
      r_target    <= 5'd1;
      r_decide    <= 1'b0;
      r_tick_cnt  <= '0;
      r_pos       <= POS_TOP;
      r_dir       <= 1'b0;
    end else if (!bus.i_active) begin
      // Soft idle: abandon any round but keep the score.
      r_state     <= S_IDLE;
      r_led       <= '0;
      r_seg       <= SEG_DASHES;
      r_tries     <= TRIES_INIT;
      r_win_pulse <= 1'b0;
      r_cnt       <= '0;
      r_decide    <= 1'b0;
      r_tick_cnt  <= '0;
      r_pos       <= POS_TOP;
      r_dir       <= 1'b0;
    end else begin
      r_win_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_led      <= '0;
          r_pos      <= POS_TOP;
          r_dir      <= 1'b0;
          r_tick_cnt <= '0;
          r_target   <= w_target_new;
          r_seg      <= {two_digit(w_target_new), C_HYP, C_HYP};
          if (w_press) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_press) begin
            // A press beats a coincident tick: the bar freezes where it is.
            r_cnt      <= popcount(r_led);
            r_decide   <= 1'b1;
            r_tick_cnt <= '0;
            r_state    <= S_STOP;
          end else begin
            r_led <= w_mask;
            if (w_tick) begin
              r_tick_cnt <= '0;
              if (!r_dir && r_pos == 4'd0) begin
                r_dir <= 1'b1;
                r_pos <= 4'd1;
              end else if (r_dir && r_pos == POS_TOP) begin
                r_dir <= 1'b0;
                r_pos <= POS_TOP_M1;
              end else begin
                r_pos <= r_dir ? r_pos + 4'd1 : r_pos - 4'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (r_decide) begin
            r_decide <= 1'b0;
            if (r_cnt == r_target) begin
              r_state     <= S_WIN;
              r_win_pulse <= 1'b1;
              r_seg       <= {C_G, C_O, C_O, C_D};
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            end else if (r_tries > 3'd1) begin
              r_tries <= r_tries - 3'd1;
              r_seg   <= {two_digit(r_cnt), (r_cnt < r_target) ? {C_U, C_P} : {C_D, C_N}};
            end else begin
              r_tries <= 3'd0;
              r_state <= S_LOSE;
              r_led   <= '0;
              r_seg   <= {C_L, C_O, C_S, C_E};
            end
          end else if (w_press) begin
            r_state <= S_RUN;
            r_seg   <= {two_digit(r_target), C_HYP, C_HYP};
          end
        end
        S_WIN, S_LOSE: begin
          if (r_state == S_LOSE) r_led <= '0;
          if (w_press) begin
            r_state  <= S_IDLE;
            r_tries  <= TRIES_INIT;
            r_led    <= '0;
            r_pos    <= POS_TOP;
            r_dir    <= 1'b0;
            r_target <= w_target_new;
            r_seg    <= {two_digit(w_target_new), C_HYP, C_HYP};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_led       = r_led;
  assign bus.o_seg_data  = r_seg;
  assign bus.o_score     = r_score;
  assign bus.o_win_pulse = r_win_pulse;
endmodule

// File: tb/tb_led_count_game.sv
// Bench for led_count_game: directed game scenarios plus randomized rounds, every cycle
// checked against a game-level model (triangle-wave bar position, round bookkeeping).
module tb_led_count_game;
  localparam int N  = 8;
  localparam int TC = 4;
  localparam int MT = 2;
  localparam logic [4:0] HYP = 5'd10;

  typedef enum int {P_IDLE, P_RUN, P_DECIDE, P_STOP, P_WIN, P_LOSE} phase_t;

  logic clk = 1'b0;
  logic reset;
  led_count_game_if #(.N_LED(N)) bus ();

  led_count_game #(.N_LED(N), .TICK_CYCLES(TC), .MAX_TRIES(MT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  phase_t      ph;
  int          target, ticks, runcyc, cnt, tries, score, pos_before;
  logic [7:0]  m_led;
  bit          pulse, hyph, btn_prev;
  logic [15:0] f_lfsr;

  function automatic logic [9:0] dig(input int v);
    return (v >= 10) ? {5'd1, 5'(v - 10)} : {5'd0, 5'(v)};
  endfunction

  // Bar position after k ticks of a round: a triangle wave starting at the top going down.
  function automatic int tri_pos(input int k);
    int m;
    m = k % (2 * (N - 1));
    return (m <= N - 1) ? (N - 1 - m) : (m - (N - 1));
  endfunction

  function automatic logic [7:0] mask(input int p);
    logic [7:0] ff;
    ff = 8'hFF;
    return ff << p;
  endfunction

  function automatic logic [19:0] exp_seg();
    case (ph)
      P_IDLE:  return hyph ? {HYP, HYP, HYP, HYP} : {dig(target), HYP, HYP};
      P_STOP:  return {dig(cnt), (cnt < target) ? {5'd15, 5'd16} : {5'd19, 5'd20}};
      P_WIN:   return {5'd9, 5'd17, 5'd17, 5'd19};
      P_LOSE:  return {5'd21, 5'd17, 5'd5, 5'd14};
      default: return {dig(target), HYP, HYP};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lfsr(input logic [15:0] v);
    int r;
    f_lfsr = v;
    force dut.r_lfsr = f_lfsr;
    r = int'(v[3:0]);
    if (r >= N) r = r - N;
    target = r + 1;
  endtask

  task automatic model_edge(input bit p_raw);
    bit pe;
    pe = p_raw && !btn_prev && bus.i_active;
    btn_prev = p_raw;
    pulse = 1'b0;
    if (!bus.i_active) begin
      ph = P_IDLE; m_led = '0; tries = MT; hyph = 1'b1;
      return;
    end
    case (ph)
      P_IDLE: begin
        hyph = 1'b0; m_led = '0;
        if (pe) begin ph = P_RUN; ticks = 0; runcyc = 0; end
      end
      P_RUN: begin
        if (pe) begin
          cnt = $countones(m_led); ph = P_DECIDE;
        end else begin
          m_led = mask(tri_pos(ticks));
          if (runcyc % TC == TC - 1) ticks++;
          runcyc++;
        end
      end
      P_DECIDE: begin
        if (cnt == target) begin
          ph = P_WIN; pulse = 1'b1;
          if (score < 255) score++;
        end else if (tries > 1) begin
          tries--; ph = P_STOP;
        end else begin
          tries = 0; ph = P_LOSE; m_led = '0;
        end
      end
      P_STOP: if (pe) begin ph = P_RUN; runcyc = 0; end
      default: if (pe) begin ph = P_IDLE; tries = MT; m_led = '0; hyph = 1'b0; end
    endcase
  endtask

  task automatic check_all();
    check("led", 32'(bus.o_led), 32'(m_led));
    if (ph != P_DECIDE) check("seg", 32'(bus.o_seg_data), 32'(exp_seg()));
    check("dp", 32'(bus.o_dp_data), 32'((1 << tries) - 1));
    check("score", 32'(bus.o_score), 32'(score));
    check("win_pulse", 32'(bus.o_win_pulse), 32'(pulse));
  endtask

  task automatic step(input bit p);
    bus.i_btn_go_stop = p;
    @(posedge clk);
    model_edge(p);
    #1;
    bus.i_btn_go_stop = 1'b0;
    check_all();
  endtask

  task automatic run_until_led(input logic [7:0] want, input string tag);
    for (int k = 0; k < 200 && m_led != want; k++) step(1'b0);
    check(tag, 32'(bus.o_led), 32'(want));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.i_active = 1'b1;
    bus.i_btn_go_stop = 1'b0;
    set_lfsr(16'h000B);
    #12;
    check("rst_led", 32'(bus.o_led), 32'h0);
    check("rst_seg", 32'(bus.o_seg_data), 32'({HYP, HYP, HYP, HYP}));
    check("rst_dp", 32'(bus.o_dp_data), 32'h3);
    check("rst_score", 32'(bus.o_score), 32'h0);
    check("rst_pulse", 32'(bus.o_win_pulse), 32'h0);
    ph = P_IDLE; m_led = '0; tries = MT; score = 0; hyph = 1'b1; btn_prev = 1'b0;
    pulse = 1'b0; cnt = 0; ticks = 0; runcyc = 0;
    @(negedge clk);
    reset = 1'b0;

    // Target 4 from lfsr[3:0] = 11, shown while idle and held through RUN.
    step(1'b0); step(1'b0);
    check("idle_target", 32'(bus.o_seg_data), 32'({5'd0, 5'd4, HYP, HYP}));
    step(1'b1);
    for (int k = 0; k < 100 && ticks < 8; k++) step(1'b0);
    check("run_target", 32'(bus.o_seg_data), 32'({5'd0, 5'd4, HYP, HYP}));
    step(1'b0);
    check("bounce_led_fe", 32'(bus.o_led), 32'hFE);

    // Hit: 4 lit LEDs against target 4.
    run_until_led(8'hF0, "reach_f0");
    step(1'b1); step(1'b0);
    check("win_pulse_hi", 32'(bus.o_win_pulse), 32'h1);
    check("win_seg", 32'(bus.o_seg_data), 32'({5'd9, 5'd17, 5'd17, 5'd19}));
    check("win_score", 32'(bus.o_score), 32'd1);
    step(1'b0);
    check("win_pulse_lo", 32'(bus.o_win_pulse), 32'h0);

    // Two misses lose the round.
    step(1'b1); step(1'b0); step(1'b1);
    run_until_led(8'hFC, "reach_fc");
    step(1'b1); step(1'b0);
    check("miss_seg", 32'(bus.o_seg_data), 32'({5'd0, 5'd6, 5'd19, 5'd20}));
    check("miss_dp", 32'(bus.o_dp_data), 32'h1);
    step(1'b0); step(1'b1);
    run_until_led(8'hC0, "reach_c0");
    step(1'b1); step(1'b0);
    check("lose_seg", 32'(bus.o_seg_data), 32'({5'd21, 5'd17, 5'd5, 5'd14}));
    step(1'b0); step(1'b1);
    check("lose_idle_dp", 32'(bus.o_dp_data), 32'h3);

    // Active drop while stopped abandons the round, score kept.
    step(1'b0); step(1'b1);
    run_until_led(8'hFE, "reach_fe");
    step(1'b1); step(1'b0);
    bus.i_active = 1'b0;
    step(1'b0);
    check("drop_seg", 32'(bus.o_seg_data), 32'({HYP, HYP, HYP, HYP}));
    check("drop_score", 32'(bus.o_score), 32'd1);
    bus.i_active = 1'b1;

    // Press landing on a tick cycle: the bar must not advance.
    step(1'b0); step(1'b0); step(1'b1);
    for (int k = 0; k < 8 && (runcyc % TC) != TC - 1; k++) step(1'b0);
    pos_before = tri_pos(ticks);
    step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
    check("press_tick", 32'(bus.o_led), 32'(mask(pos_before)));
    bus.i_active = 1'b0;
    step(1'b0);
    bus.i_active = 1'b1;

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      set_lfsr(16'($urandom));
      if (ph == P_WIN || ph == P_LOSE) begin step(1'b0); step(1'b1); end
      repeat ($urandom_range(1, 3)) step(1'b0);
      step(1'b1);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 10)) step(1'b0);
        bus.i_active = 1'b0;
        repeat ($urandom_range(1, 3)) step(1'b0);
        check("abandon_score", 32'(bus.o_score), 32'(score));
        bus.i_active = 1'b1;
        continue;
      end
      for (int t = 0; t < 8 && ph == P_RUN; t++) begin
        repeat ($urandom_range(1, 14)) step(1'b0);
        step(1'b1); step(1'b0);
        if (ph == P_STOP) begin
          repeat ($urandom_range(0, 2)) step(1'b0);
          step(1'b1);
        end
      end
      $display("[TB] round %0d target=%0d score=%0d tries=%0d", r, target, score, tries);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
